// File: rtl/led_shift_tx.sv
// led_shift_tx: serial transmitter for a chain of 74HC595-class LED drivers.
// Accepts a WIDTH-bit pattern on a LOAD/READY handshake and shifts it out on
// SDO/SCLK, one bit per SCLK period of 2*CLK_DIV cycles. It then holds LAT
// high for CLK_DIV cycles and pulses DONE for one cycle. All outputs are
// registered.
// Build option: define SHIFT_LSB_FIRST_EN to transmit DATA[0] first.
// When it is left undefined (the default), DATA[WIDTH-1] is transmitted first.
module led_shift_tx #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] DATA,
    input  logic             LOAD,
    output logic             READY,
    output logic             SDO,
    output logic             SCLK,
    output logic             LAT,
    output logic             DONE
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t           state, state_n;
    logic [DW-1:0]    div_cnt, div_n;
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic             ready_n, sdo_n, sclk_n, lat_n, done_n;
    logic             div_end;

    // The bit that goes on SDO next, taken from the transmit end of the register.
    function automatic logic first_bit(input logic [WIDTH-1:0] v);
`ifdef SHIFT_LSB_FIRST_EN
        return v[0];
`else
        return v[WIDTH-1];
`endif
    endfunction

    // Drop the bit just sent; a zero fills in from the far end.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
`ifdef SHIFT_LSB_FIRST_EN
        return v >> 1;
`else
        return v << 1;
`endif
    endfunction

    assign div_end = (div_cnt == DIV_LAST);

    // Next-state and next-output decode; every phase lasts CLK_DIV cycles.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        sr_n    = sr;
        ready_n = READY;
        sdo_n   = SDO;
        sclk_n  = SCLK;
        lat_n   = LAT;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (LOAD && READY) begin
                    sr_n    = DATA;
                    sdo_n   = first_bit(DATA);
                    sclk_n  = 1'b0;
                    ready_n = 1'b0;
                    div_n   = '0;
                    bit_n   = '0;
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_n   = '0;
                    sclk_n  = 1'b1;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    div_n  = '0;
                    sclk_n = 1'b0;
                    if (bit_cnt == BIT_LAST) begin
                        // Last bit clocked in: park SDO low and latch the chain.
                        sdo_n   = 1'b0;
                        lat_n   = 1'b1;
                        state_n = LATCH;
                    end else begin
                        sr_n    = advance(sr);
                        sdo_n   = first_bit(advance(sr));
                        bit_n   = bit_cnt + BW'(1);
                        state_n = SHIFT_LO;
                    end
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            LATCH: begin
                if (div_end) begin
                    div_n   = '0;
                    lat_n   = 1'b0;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Control state and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            READY   <= 1'b1;
            SDO     <= 1'b0;
            SCLK    <= 1'b0;
            LAT     <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            READY   <= ready_n;
            SDO     <= sdo_n;
            SCLK    <= sclk_n;
            LAT     <= lat_n;
            DONE    <= done_n;
        end
    end

    // Pattern shift register; only written on accept and bit advance, so no reset.
    always_ff @(posedge CLK) begin
        sr <= sr_n;
    end

endmodule
